divisor_secuencial: RTL and testbench



---
 rtl/divisor_secuencial.sv | 114 +++++++++++
 tb/tb_divisor_secuencial.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/divisor_secuencial.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/done handshake, registered Q/R/DZ held between operations.
module divisor_secuencial #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] A,
    input  logic [NUM_BITS-1:0] B,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] Q,
    output logic [NUM_BITS-1:0] R,
    output logic                DZ
);
    localparam int CW = $clog2(NUM_BITS) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state, state_next;
    logic [NUM_BITS-1:0] dvd;      // dividend shifting out, quotient shifting in
    logic [NUM_BITS-1:0] dsr;      // latched divisor
    logic [NUM_BITS:0]   rem;      // partial remainder, one extra bit so the trial never overflows
    logic [CW-1:0]       cnt;

    logic                load, load_dz, last;
    logic [NUM_BITS:0]   rem_sh, rem_nx;
    logic [NUM_BITS+1:0] trial;
    logic                fits;
    logic [NUM_BITS-1:0] dvd_nx;

    // One restoring step: shift {rem,dvd}, trial-subtract, keep on no borrow
    always_comb begin
        rem_sh = {rem[NUM_BITS-1:0], dvd[NUM_BITS-1]};
        trial  = {1'b0, rem_sh} - {2'b00, dsr};
        fits   = ~trial[NUM_BITS+1];
        rem_nx = fits ? trial[NUM_BITS:0] : rem_sh;
        dvd_nx = {dvd[NUM_BITS-2:0], fits};
        last   = (cnt == CW'(NUM_BITS - 1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and handshake outputs; DONE accepts a new start like IDLE
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_dz    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    if (B == '0) begin
                        load_dz    = 1'b1;
                        state_next = DONE;
                    end else begin
                        load       = 1'b1;
                        state_next = CALC;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Working registers: load operands on accept, iterate while in CALC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd <= '0;
            dsr <= '0;
            rem <= '0;
            cnt <= '0;
        end else if (load) begin
            dvd <= A;
            dsr <= B;
            rem <= '0;
            cnt <= '0;
        end else if (state == CALC) begin
            dvd <= dvd_nx;
            rem <= rem_nx;
            cnt <= cnt + CW'(1);
        end
    end

    // Result registers: written only on the edge entering DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q  <= '0;
            R  <= '0;
            DZ <= 1'b0;
        end else if (load_dz) begin
            Q  <= '1;
            R  <= A;
            DZ <= 1'b1;
        end else if (state == CALC && last) begin
            Q  <= dvd_nx;
            R  <= rem_nx[NUM_BITS-1:0];
            DZ <= 1'b0;
        end
    end
endmodule

// File: tb/tb_divisor_secuencial.sv
// Self-checking bench for divisor_secuencial (NUM_BITS=4).
module tb_divisor_secuencial;
    localparam int N = 4;

    logic         clk = 0, rst = 0, start = 0;
    logic [N-1:0] A = '0, B = '0;
    logic         busy, done, DZ;
    logic [N-1:0] Q, R;

    int checks = 0, errors = 0;

    divisor_secuencial #(.NUM_BITS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .Q(Q), .R(R), .DZ(DZ)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer division, divide-by-zero as all-ones / A
    function automatic logic [N-1:0] ref_q(input int a, input int b);
        return (b == 0) ? N'((1 << N) - 1) : N'(a / b);
    endfunction
    function automatic logic [N-1:0] ref_r(input int a, input int b);
        return (b == 0) ? N'(a) : N'(a % b);
    endfunction
    function automatic int ref_lat(input int b);
        return (b == 0) ? 1 : N + 1;
    endfunction

    // Drive one start pulse, return edges from accept (inclusive) to done; -1 on timeout
    task automatic do_op(input int a, input int b, output int lat);
        @(negedge clk);
        A = N'(a); B = N'(b); start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1; #7; rst = 0;
        @(negedge clk);
        checks++; if (Q !== 0 || R !== 0 || DZ !== 0) begin errors++; $display("FAIL reset_out Q=%0d R=%0d DZ=%0b expected 0/0/0", Q, R, DZ); end
        checks++; if (busy !== 0 || done !== 0) begin errors++; $display("FAIL reset_hs busy=%0b done=%0b expected 0/0", busy, done); end
        for (int i = 0; i < 4; i++) begin
            A = N'($urandom); B = N'($urandom);
            @(negedge clk);
        end
        checks++; if (Q !== 0 || R !== 0 || busy !== 0 || done !== 0) begin errors++; $display("FAIL idle_toggle Q=%0d R=%0d busy=%0b done=%0b expected all 0", Q, R, busy, done); end
    endtask

    task automatic test_basic();
        int lat;
        int ta[4] = '{13, 15, 3, 0};
        int tb[4] = '{4, 1, 7, 5};
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], lat);
            checks++; if (lat !== ref_lat(tb[i])) begin errors++; $display("FAIL basic_lat %0d/%0d got %0d expected %0d", ta[i], tb[i], lat, ref_lat(tb[i])); end
            checks++; if (Q !== ref_q(ta[i], tb[i]) || R !== ref_r(ta[i], tb[i]) || DZ !== 0) begin
                errors++; $display("FAIL basic_res %0d/%0d got Q=%0d R=%0d DZ=%0b expected Q=%0d R=%0d DZ=0", ta[i], tb[i], Q, R, DZ, ref_q(ta[i], tb[i]), ref_r(ta[i], tb[i])); end
            // done lasts one cycle and results hold while inputs wander
            @(negedge clk);
            checks++; if (done !== 0) begin errors++; $display("FAIL done_pulse got %0b expected 0", done); end
            A = N'($urandom); B = N'($urandom);
            repeat (3) @(negedge clk);
            checks++; if (Q !== ref_q(ta[i], tb[i]) || R !== ref_r(ta[i], tb[i])) begin errors++; $display("FAIL hold Q=%0d R=%0d expected %0d %0d", Q, R, ref_q(ta[i], tb[i]), ref_r(ta[i], tb[i])); end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        do_op(5, 0, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL dz_lat got %0d expected 1", lat); end
        checks++; if (Q !== 4'hF || R !== 5 || DZ !== 1) begin errors++; $display("FAIL dz_res got Q=%0h R=%0d DZ=%0b expected F 5 1", Q, R, DZ); end
        do_op(9, 3, lat);
        checks++; if (Q !== 3 || R !== 0 || DZ !== 0 || lat !== N + 1) begin errors++; $display("FAIL after_dz got Q=%0d R=%0d DZ=%0b lat=%0d expected 3 0 0 %0d", Q, R, DZ, lat, N + 1); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        A = 13; B = 4; start = 1;
        @(posedge clk);
        @(negedge clk);
        A = 8; B = 3;               // start stays high through CALC
        n = 1;
        while (!done && n < 20) begin
            checks++; if (busy !== 1) begin errors++; $display("FAIL b2b_busy got %0b expected 1", busy); end
            @(negedge clk); n++;
        end
        checks++; if (n !== N + 1 || Q !== 3 || R !== 1) begin errors++; $display("FAIL b2b_first lat=%0d Q=%0d R=%0d expected %0d 3 1", n, Q, R, N + 1); end
        @(posedge clk);             // accepted straight out of DONE
        @(negedge clk);
        start = 0;
        checks++; if (busy !== 1) begin errors++; $display("FAIL b2b_accept busy=%0b expected 1", busy); end
        n = 1;
        while (!done && n < 20) begin @(negedge clk); n++; end
        checks++; if (n !== N + 1 || Q !== 2 || R !== 2) begin errors++; $display("FAIL b2b_second lat=%0d Q=%0d R=%0d expected %0d 2 2", n, Q, R, N + 1); end
    endtask

    task automatic test_async_reset();
        int lat;
        bit seen = 0;
        @(negedge clk);
        A = 13; B = 4; start = 1;
        @(posedge clk);
        @(negedge clk); start = 0;
        @(posedge clk); @(posedge clk);
        #2 rst = 1;
        #1;
        checks++; if (busy !== 0 || done !== 0 || Q !== 0 || R !== 0 || DZ !== 0) begin
            errors++; $display("FAIL async_rst busy=%0b done=%0b Q=%0d R=%0d DZ=%0b expected all 0", busy, done, Q, R, DZ); end
        @(negedge clk); rst = 0;
        repeat (N + 2) begin @(negedge clk); if (done) seen = 1; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_no_done got done pulse expected none"); end
        do_op(14, 3, lat);
        checks++; if (Q !== 4 || R !== 2 || lat !== N + 1) begin errors++; $display("FAIL post_rst Q=%0d R=%0d lat=%0d expected 4 2 %0d", Q, R, lat, N + 1); end
    endtask

    task automatic test_sweep();
        int lat, a, b;
        int perm = int'($urandom_range(0, 255));
        for (int i = 0; i < 256; i++) begin
            a = ((i ^ perm) >> 4) & 15;
            b = (i ^ perm) & 15;
            do_op(a, b, lat);
            checks++; if (Q !== ref_q(a, b) || R !== ref_r(a, b) || DZ !== (b == 0) || lat !== ref_lat(b)) begin
                errors++; $display("FAIL sweep %0d/%0d got Q=%0d R=%0d DZ=%0b lat=%0d expected Q=%0d R=%0d DZ=%0b lat=%0d",
                                   a, b, Q, R, DZ, lat, ref_q(a, b), ref_r(a, b), b == 0, ref_lat(b)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_async_reset();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
